// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: machine widths, PC step and the fetch entry that
// travels from the fetch stage to decode.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] word;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with first-word fall-through head and a
// single-cycle flush used when fetch is redirected.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Flush wins over any push/pop in the same cycle so a redirect leaves it empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        head = storage[rd_ptr];
    end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues one instruction-memory read per cycle
// under a credit limit and hands fetched words to decode through a prefetch FIFO.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_read_enable,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_value,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] START_PC = RESET_PC & ~32'h3;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   fifo_count;
    logic [$bits(fetch_entry_t)-1:0] head_bits;
    fetch_entry_t    head_entry;
    fetch_entry_t    push_entry;
    logic            push;
    logic            pop;
    logic            issue;
    logic [CW:0]     occupancy;

    // A head being popped this cycle frees its slot, which keeps one fetch per cycle.
    always_comb begin
        head_entry = head_bits;
        inst_valid = (fifo_count != '0);
        pop        = inst_valid && inst_ready;
        push       = inflight && !redirect_valid;
        push_entry = '{word: mem_read_value, pc: inflight_pc};
        occupancy  = {1'b0, fifo_count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
        issue      = reset_n && !redirect_valid && (occupancy < (CW + 1)'(FIFO_DEPTH));
    end

    always_comb begin
        mem_read_enable  = issue;
        mem_read_address = {2'b00, fetch_pc[31:2]};
        inst_word        = inst_valid ? head_entry.word : '0;
        inst_pc          = inst_valid ? head_entry.pc : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= START_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
            end else if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) prefetch (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (fifo_count),
        .head     (head_bits)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle tables for the fixed scenarios, hand sequences
// for reset/wrap corner cases, and a random stream against a program-order PC model.
module tb_instruction_fetch;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_word;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_read_enable;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_value;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;

    logic        redirect_valid_w = 1'b0;
    logic [31:0] redirect_pc_w = '0;
    logic        mem_read_enable_w;
    logic [31:0] mem_read_address_w;
    logic [31:0] mem_read_value_w;
    logic        inst_valid_w;
    logic        inst_ready_w = 1'b1;
    logic [31:0] inst_word_w;
    logic [31:0] inst_pc_w;

    int passed = 0;
    int total = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_read_enable (mem_read_enable),
        .mem_read_address(mem_read_address),
        .mem_read_value  (mem_read_value),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_word       (inst_word),
        .inst_pc         (inst_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid_w),
        .redirect_pc     (redirect_pc_w),
        .mem_read_enable (mem_read_enable_w),
        .mem_read_address(mem_read_address_w),
        .mem_read_value  (mem_read_value_w),
        .inst_valid      (inst_valid_w),
        .inst_ready      (inst_ready_w),
        .inst_word       (inst_word_w),
        .inst_pc         (inst_pc_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
        return 32'h1000 + word_addr;
    endfunction

    // Memory answers one cycle after a request; garbage otherwise.
    always @(posedge clock) begin
        if (mem_read_enable) mem_read_value <= mem_word(mem_read_address);
        else mem_read_value <= $urandom;
        if (mem_read_enable_w) mem_read_value_w <= mem_word(mem_read_address_w);
        else mem_read_value_w <= $urandom;
    end

    function automatic vec_t make_vec(input logic rst, input logic ready, input logic redir,
                                      input logic [31:0] rpc, input logic en,
                                      input logic [31:0] addr, input logic valid,
                                      input logic [31:0] pc, input logic [31:0] word);
        vec_t v;
        v.rst = rst; v.ready = ready; v.redir = redir; v.redir_pc = rpc;
        v.exp_en = en; v.exp_addr = addr; v.exp_valid = valid;
        v.exp_pc = pc; v.exp_word = word;
        return v;
    endfunction

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic ready, input logic redir, input logic [31:0] rpc);
        inst_ready = ready;
        redirect_valid = redir;
        redirect_pc = rpc;
    endtask

    task automatic do_reset();
        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        reset_n = 1'b0;
        #1;
        check_value("reset_en", 32'(mem_read_enable), 32'd0);
        check_value("reset_valid", 32'(inst_valid), 32'd0);
        check_value("reset_word", inst_word, 32'h0);
        check_value("reset_pc", inst_pc, 32'h0);
        check_value("reset_addr_wrap", mem_read_address_w, 32'h3FFF_FFFE);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check_value($sformatf("vec%0d_en", idx), 32'(mem_read_enable), 32'(v.exp_en));
        if (v.exp_en) check_value($sformatf("vec%0d_addr", idx), mem_read_address, v.exp_addr);
        check_value($sformatf("vec%0d_valid", idx), 32'(inst_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check_value($sformatf("vec%0d_pc", idx), inst_pc, v.exp_pc);
            check_value($sformatf("vec%0d_word", idx), inst_word, v.exp_word);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        expect_empty;
        int          accepted;
        logic        r_ready;
        logic        r_redir;
        logic [31:0] r_pc;

        // Streaming from reset with decode always ready.
        for (int k = 0; k < 10; k++)
            vecs.push_back(make_vec(k == 0, 1'b1, 1'b0, 32'h0, 1'b1, 32'(k), k >= 2,
                                    32'(4 * (k - 2)), 32'h1000 + 32'(k - 2)));
        // Decode stalled for ten cycles, then released.
        for (int k = 0; k < 16; k++)
            vecs.push_back(make_vec(k == 0, k >= 10, 1'b0, 32'h0, (k < 2) || (k >= 10),
                                    (k < 2) ? 32'(k) : ((k < 10) ? 32'd2 : 32'(k - 8)),
                                    k >= 2, (k < 10) ? 32'h0 : 32'(4 * (k - 10)),
                                    32'h1000 + ((k < 10) ? 32'h0 : 32'(k - 10))));
        // Redirect with an entry buffered and a read in flight, then back-to-back redirects.
        vecs.push_back(make_vec(1, 0, 0, 32'h0,   1, 32'h00, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 0, 0, 32'h0,   1, 32'h01, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 0, 1, 32'h43,  0, 32'h00, 1, 32'h0,   32'h1000));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h10, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h11, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h12, 1, 32'h40,  32'h1010));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h13, 1, 32'h44,  32'h1011));
        vecs.push_back(make_vec(0, 1, 1, 32'h100, 0, 32'h00, 1, 32'h48,  32'h1012));
        vecs.push_back(make_vec(0, 1, 1, 32'h203, 0, 32'h00, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h80, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h81, 0, 32'h0,   32'h0));
        vecs.push_back(make_vec(0, 1, 0, 32'h0,   1, 32'h82, 1, 32'h200, 32'h1080));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            apply_stimulus(vecs[i].ready, vecs[i].redir, vecs[i].redir_pc);
            #1;
            check_output(vecs[i], i);
            @(negedge clock);
        end

        // PC wrap across the top of the address space.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k == 2) begin
                check_value("wrap_pc0", inst_pc_w, 32'hFFFF_FFF8);
                check_value("wrap_word0", inst_word_w, mem_word(32'h3FFF_FFFE));
            end else if (k == 3) begin
                check_value("wrap_pc1", inst_pc_w, 32'hFFFF_FFFC);
                check_value("wrap_word1", inst_word_w, mem_word(32'h3FFF_FFFF));
            end else if (k == 4) begin
                check_value("wrap_pc2", inst_pc_w, 32'h0000_0000);
                check_value("wrap_word2", inst_word_w, 32'h1000);
            end
            @(negedge clock);
        end

        // Reset pulse between clock edges while streaming.
        do_reset();
        repeat (4) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_value("pulse_en", 32'(mem_read_enable), 32'd0);
        check_value("pulse_valid", 32'(inst_valid), 32'd0);
        check_value("pulse_word", inst_word, 32'h0);
        check_value("pulse_pc", inst_pc, 32'h0);
        #1 reset_n = 1'b1;
        #1;
        check_value("restart_w0_en", 32'(mem_read_enable), 32'd1);
        check_value("restart_w0_addr", mem_read_address, 32'h0);
        check_value("restart_w0_valid", 32'(inst_valid), 32'd0);
        @(negedge clock); #1;
        check_value("restart_w1_valid", 32'(inst_valid), 32'd0);
        @(negedge clock); #1;
        check_value("restart_w2_pc", inst_pc, 32'h0);
        check_value("restart_w2_word", inst_word, 32'h1000);
        @(negedge clock); #1;
        check_value("restart_w3_pc", inst_pc, 32'h4);
        check_value("restart_w3_word", inst_word, 32'h1001);
        @(negedge clock);

        // Random ready/redirects against the program-order model.
        do_reset();
        exp_pc = 32'h0;
        expect_empty = 1'b0;
        accepted = 0;
        for (int c = 0; c < 600; c++) begin
            r_ready = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc = $urandom;
            apply_stimulus(r_ready, r_redir, r_pc);
            #1;
            if (expect_empty) check_value($sformatf("rand%0d_flushed", c), 32'(inst_valid), 32'd0);
            if (inst_valid && r_ready) begin
                check_value($sformatf("rand%0d_pc", c), inst_pc, exp_pc);
                check_value($sformatf("rand%0d_word", c), inst_word, mem_word(exp_pc >> 2));
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (r_redir) exp_pc = r_pc & ~32'h3;
            expect_empty = r_redir;
            @(negedge clock);
        end
        check_value("rand_progress", 32'(accepted >= 150), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
